mul_rom_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer sharing one product-lookup ROM (N-bit address = {a,b}, N-bit data) among NUM_REQ requesters.

---
 rtl/mul_rom_arbiter.sv | 123 ++++++++++++
 tb/tb_mul_rom_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_rom_arbiter.sv
// Round-robin arbiter sharing one product ROM among NUM_REQ requesters.
// Define ZERO_BYPASS_EN to skip the ROM read when either operand is zero.
module mul_rom_arbiter #(
  parameter int N = 8,
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*N/2-1:0] req_a,
  input  logic [NUM_REQ*N/2-1:0] req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [N-1:0]           rsp_data,
  output logic [N-1:0]           rom_address,
  output logic                   rom_read_en,
  output logic                   rom_ce,
  input  logic [N-1:0]           rom_data,
  output logic                   busy
);

  localparam int H = N / 2;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    RESP
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [H-1:0]    a_q, a_d;
  logic [H-1:0]    b_q, b_d;
  logic [N-1:0]    data_q, data_d;
  logic [ID_W-1:0] gnt_idx;
  logic            gnt_found;
  logic            zero_op;
  logic            rom_en;
  int              idx;

  // Search starts just past the previous winner, wrapping mod NUM_REQ
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(idx);
      end
    end
  end

`ifdef ZERO_BYPASS_EN
  assign zero_op = (a_q == '0) || (b_q == '0);
`else
  assign zero_op = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    data_d    = data_q;
    req_ready = '0;
    rom_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_found && !rst) begin
          req_ready[gnt_idx] = 1'b1;
          a_d     = req_a[int'(gnt_idx)*H +: H];
          b_d     = req_b[int'(gnt_idx)*H +: H];
          id_d    = gnt_idx;
          last_d  = gnt_idx;
          state_d = READ;
        end
      end
      READ: begin
        rom_en  = !zero_op;
        data_d  = zero_op ? '0 : rom_data;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= ID_W'(NUM_REQ - 1);
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
    end
  end

  assign rsp_valid   = (state_q == RESP);
  assign busy        = (state_q != IDLE);
  assign rsp_id      = id_q;
  assign rsp_data    = data_q;
  assign rom_address = {a_q, b_q};
  assign rom_ce      = rom_en;
  assign rom_read_en = rom_en;

endmodule

// File: tb/tb_mul_rom_arbiter.sv
// Bench for mul_rom_arbiter: product ROM model plus a
// transaction-level round-robin reference.
module tb_mul_rom_arbiter;

  localparam int N  = 8;
  localparam int NR = 4;
  localparam int H  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*H-1:0] req_a;
  logic [NR*H-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [N-1:0]    rsp_data;
  logic [N-1:0]    rom_address;
  logic            rom_read_en;
  logic            rom_ce;
  logic [N-1:0]    rom_data;
  logic            busy;

  int n_cmp = 0;
  int n_bad = 0;
  int last_g;
  logic [H-1:0] opa [NR];
  logic [H-1:0] opb [NR];

  mul_rom_arbiter #(.N(N), .NUM_REQ(NR)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rom_address(rom_address), .rom_read_en(rom_read_en),
    .rom_ce(rom_ce), .rom_data(rom_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Product-table ROM: combinational, 0 when not enabled
  assign rom_data = (rom_ce && rom_read_en) ?
    ({4'b0, rom_address[7:4]} * {4'b0, rom_address[3:0]}) : 8'h00;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] prod(int a, int b);
    return 8'((a * b) & 255);
  endfunction

  function automatic int pick(logic [NR-1:0] v, int last);
    for (int k = 1; k <= NR; k++)
      if (v[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  function automatic logic [NR-1:0] onehot(int g);
    logic [NR-1:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic exp_ce(int a, int b);
`ifdef ZERO_BYPASS_EN
    return (a != 0) && (b != 0);
`else
    return 1'b1;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ops();
    for (int i = 0; i < NR; i++) begin
      req_a[i*H +: H] = opa[i];
      req_b[i*H +: H] = opb[i];
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NR; i++) begin
      opa[i] = 4'($urandom_range(0, 15));
      opb[i] = 4'($urandom_range(0, 15));
    end
    drive_ops();
  endtask

  task automatic test_reset();
    logic [31:0] o;
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    req_a = '0;
    req_b = '0;
    tick();
    tick();
    o = {8'(req_ready), 8'(rsp_valid), 8'(rsp_id), 8'(busy)};
    n_cmp++;
    if (o !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_ctl: got %h want 0", o);
    end
    o = {rsp_data, rom_address, 8'(rom_ce), 8'(rom_read_en)};
    n_cmp++;
    if (o !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 0", o);
    end
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if ({rom_ce, busy} !== 2'b00) begin
        n_bad++;
        $display("FAIL idle_quiet c%0d: got ce=%b busy=%b want 0 0",
                 c, rom_ce, busy);
      end
    end
    last_g = NR - 1;
  endtask

  task automatic test_single();
    opa[2] = 4'd7;
    opb[2] = 4'd9;
    drive_ops();
    req_valid = 4'b0100;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_bad++;
      $display("FAIL single_rdy: got %b want 0100", req_ready);
    end
    tick();
    req_valid = '0;
    #1;
    n_cmp++;
    if ({rom_address, rom_ce, rsp_valid} !== {8'h79, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL single_rom: got addr=%h ce=%b v=%b want 79 1 0",
               rom_address, rom_ce, rsp_valid);
    end
    tick();
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd2, 8'd63}) begin
      n_bad++;
      $display("FAIL single_rsp: got v=%b id=%0d d=%0d want 1 2 63",
               rsp_valid, rsp_id, rsp_data);
    end
    tick();
    n_cmp++;
    if ({rsp_valid, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL single_done: got v=%b busy=%b want 0 0",
               rsp_valid, busy);
    end
    last_g = 2;
  endtask

  task automatic test_zero_operand();
    opa[1] = 4'd0;
    opb[1] = 4'd5;
    drive_ops();
    req_valid = 4'b0010;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_bad++;
      $display("FAIL zero_rdy: got %b want 0010", req_ready);
    end
    tick();
    req_valid = '0;
    #1;
    n_cmp++;
    if ({rom_ce, rom_read_en} !== {2{exp_ce(0, 5)}}) begin
      n_bad++;
      $display("FAIL zero_ce: got %b%b want %b",
               rom_ce, rom_read_en, exp_ce(0, 5));
    end
    tick();
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_data, rom_ce} !==
        {1'b1, 2'd1, 8'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL zero_rsp: got v=%b id=%0d d=%0d ce=%b want 1 1 0 0",
               rsp_valid, rsp_id, rsp_data, rom_ce);
    end
    tick();
    last_g = 1;
  endtask

  task automatic test_back_to_back();
    int cur;
    logic [NR-1:0] exp;
    rand_ops();
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    cur = last_g;
    for (int c = 0; c < 24; c++) begin
      #1;
      if (c % 3 == 0) begin
        cur = pick(4'b1111, last_g);
        exp = onehot(cur);
        last_g = cur;
      end else begin
        exp = '0;
      end
      n_cmp++;
      if (req_ready !== exp) begin
        n_bad++;
        $display("FAIL b2b_rdy c%0d: got %b want %b", c, req_ready, exp);
      end
      if (c % 3 == 2) begin
        n_cmp++;
        if ({rsp_id, rsp_data} !== {2'(cur), prod(opa[cur], opb[cur])}) begin
          n_bad++;
          $display("FAIL b2b_rsp c%0d: got id=%0d d=%0d want %0d %0d",
                   c, rsp_id, rsp_data, cur, prod(opa[cur], opb[cur]));
        end
      end
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_random();
    logic [NR-1:0] m;
    int g;
    for (int t = 0; t < 30; t++) begin
      rand_ops();
      m = 4'($urandom_range(1, 15));
      req_valid = m;
      rsp_ready = 1'b1;
      #1;
      g = pick(m, last_g);
      n_cmp++;
      if ({req_ready, busy} !== {onehot(g), 1'b0}) begin
        n_bad++;
        $display("FAIL rnd_rdy t%0d: got %b busy=%b want %b 0",
                 t, req_ready, busy, onehot(g));
      end
      tick();
      req_valid = 4'($urandom);
      #1;
      n_cmp++;
      if ({rom_address, rom_ce, req_ready} !==
          {opa[g], opb[g], exp_ce(opa[g], opb[g]), 4'b0}) begin
        n_bad++;
        $display("FAIL rnd_read t%0d: got a=%h ce=%b r=%b want %h%h %b 0",
                 t, rom_address, rom_ce, req_ready, opa[g], opb[g],
                 exp_ce(opa[g], opb[g]));
      end
      tick();
      n_cmp++;
      if ({rsp_valid, busy, rsp_id, rsp_data, req_ready} !==
          {2'b11, 2'(g), prod(opa[g], opb[g]), 4'b0}) begin
        n_bad++;
        $display("FAIL rnd_rsp t%0d: got v=%b id=%0d d=%0d want 1 %0d %0d",
                 t, rsp_valid, rsp_id, rsp_data, g, prod(opa[g], opb[g]));
      end
      last_g = g;
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_stall();
    int g;
    int ng;
    rand_ops();
    req_valid = 4'b1111;
    #1;
    g = pick(4'b1111, last_g);
    n_cmp++;
    if (req_ready !== onehot(g)) begin
      n_bad++;
      $display("FAIL stall_rdy: got %b want %b", req_ready, onehot(g));
    end
    tick();
    rsp_ready = 1'b0;
    tick();
    for (int c = 0; c < 10; c++) begin
      #1;
      n_cmp++;
      if ({rsp_valid, rsp_id, rsp_data, req_ready} !==
          {1'b1, 2'(g), prod(opa[g], opb[g]), 4'b0}) begin
        n_bad++;
        $display("FAIL stall_hold c%0d: got v=%b id=%0d d=%0d r=%b", c,
                 rsp_valid, rsp_id, rsp_data, req_ready);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    ng = pick(4'b1111, g);
    n_cmp++;
    if ({rsp_valid, req_ready} !== {1'b0, onehot(ng)}) begin
      n_bad++;
      $display("FAIL stall_release: got v=%b r=%b want 0 %b",
               rsp_valid, req_ready, onehot(ng));
    end
    req_valid = '0;
    last_g = g;
  endtask

  task automatic test_reset_mid();
    rand_ops();
    req_valid = 4'b1111;
    tick();
    n_cmp++;
    if (rom_ce !== exp_ce(opa[pick(4'b1111, last_g)],
                          opb[pick(4'b1111, last_g)])) begin
      n_bad++;
      $display("FAIL rstmid_read: got ce=%b", rom_ce);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({rsp_valid, busy, rom_ce} !== 3'b000) begin
      n_bad++;
      $display("FAIL rstmid_clear: got v=%b busy=%b ce=%b want 0 0 0",
               rsp_valid, busy, rom_ce);
    end
    last_g = NR - 1;
    n_cmp++;
    if (req_ready !== onehot(pick(4'b1111, last_g))) begin
      n_bad++;
      $display("FAIL rstmid_prio: got %b want %b",
               req_ready, onehot(pick(4'b1111, last_g)));
    end
    tick();
    req_valid = '0;
    tick();
    n_cmp++;
    if ({rsp_valid, rsp_id, rsp_data} !==
        {1'b1, 2'd0, prod(opa[0], opb[0])}) begin
      n_bad++;
      $display("FAIL rstmid_rsp: got v=%b id=%0d d=%0d want 1 0 %0d",
               rsp_valid, rsp_id, rsp_data, prod(opa[0], opb[0]));
    end
    tick();
    last_g = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero_operand();
    test_back_to_back();
    test_random();
    test_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
